// File: rtl/fb_pkg.sv
// fb_pkg: shared types and helpers for the frame-buffer pixel writer.
//   fb_state_t   : writer FSM state encoding
//   fb_addr_bits : clog2 of the frame size, used to size the write index
package fb_pkg;

  typedef enum logic [1:0] {
    FB_IDLE   = 2'd0,
    FB_ACTIVE = 2'd1,
    FB_DONE   = 2'd2
  } fb_state_t;

  // Bits needed to index h_res*v_res pixels (minimum 1).
  function automatic int fb_addr_bits(input int h_res, input int v_res);
    int n;
    int bits;
    n    = h_res * v_res;
    bits = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) bits = i + 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/fb_xy_counter.sv
// fb_xy_counter: x/y position tracker for the incoming pixel stream.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_clear        current pixel is a start of frame, treat it as (0,0)
//   i_advance      current pixel is accepted, step the position
//   i_decim        decimation mode in force for the current pixel
//   o_x_last       current pixel is the last of its line
//   o_y_last       current pixel is on the last line
//   o_keep         current pixel must be written
// All outputs describe the pixel presented this cycle, so a SOF pixel
// reports (0,0) even though the registers still hold the old position.
module fb_xy_counter #(
  parameter int H_RES = 640,
  parameter int V_RES = 480
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_advance,
  input  logic i_decim,
  output logic o_x_last,
  output logic o_y_last,
  output logic o_keep
);

  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam logic [XW-1:0] X_MAX = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(V_RES - 1);

  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [XW-1:0] w_x;
  logic [YW-1:0] w_y;

  always_comb begin
    w_x      = i_clear ? '0 : r_x;
    w_y      = i_clear ? '0 : r_y;
    o_x_last = (w_x == X_MAX);
    o_y_last = (w_y == Y_MAX);
    o_keep   = !i_decim || (!w_x[0] && !w_y[0]);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_advance) begin
      if (o_x_last) begin
        r_x <= '0;
        r_y <= o_y_last ? '0 : w_y + 1'b1;
      end else begin
        r_x <= w_x + 1'b1;
        r_y <= w_y;
      end
    end
  end

endmodule

// File: rtl/fb_frame_writer.sv
// fb_frame_writer: frame-aware pixel writer from a valid/ready stream into
// a frame-buffer BRAM write port, one pixel per cycle, with SOF resync and
// optional 2:1 decimation in x and y.
// Ports:
//   i_clk, i_rst             clock, synchronous active-high reset
//   i_data_valid/o_data_ready/i_data  pixel stream
//   i_sof                    start of frame, marks the first pixel
//   i_decim                  2:1 subsample, sampled with the SOF pixel
//   o_bram_wr/addr/data      BRAM write port (registered)
//   o_frame_done             pulse with the final pixel's write cycle
//   o_busy                   high while a frame is in progress
//   o_frame_err              error pulse; only built with FB_WR_ERR_EN
// Build option: define FB_WR_ERR_EN to generate o_frame_err (short frame,
// or stray pixel in IDLE once per IDLE period); otherwise it is tied to 0.
//
// state     | meaning
// FB_IDLE   | waiting for SOF, non-SOF pixels dropped
// FB_ACTIVE | frame in progress, pixels stepped through x/y
// FB_DONE   | one-cycle stall after the last pixel, frame_done pulse
module fb_frame_writer
  import fb_pkg::*;
#(
  parameter int DW        = 8,
  parameter int H_RES     = 640,
  parameter int V_RES     = 480,
  parameter int BASE_ADDR = 0,
  parameter int AW        = 19
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_data_valid,
  output logic          o_data_ready,
  input  logic [DW-1:0] i_data,
  input  logic          i_sof,
  input  logic          i_decim,
  output logic          o_bram_wr,
  output logic [AW-1:0] o_bram_addr,
  output logic [DW-1:0] o_bram_data,
  output logic          o_frame_done,
  output logic          o_busy,
  output logic          o_frame_err
);

  localparam int IW = fb_addr_bits(H_RES, V_RES);

  fb_state_t     r_state;
  fb_state_t     w_state_nxt;

  logic          r_ready;
  logic          r_wr;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;
  logic          r_done;
  logic          r_busy;
  logic          r_decim;
  logic [IW-1:0] r_idx;

  logic          w_xfer;
  logic          w_sof_acc;
  logic          w_px_acc;
  logic          w_decim_eff;
  logic [IW-1:0] w_idx_cur;
  logic          w_x_last;
  logic          w_y_last;
  logic          w_keep;
  logic          w_wr_nxt;
  logic          w_ready_nxt;
  logic          w_busy_nxt;
  logic          w_done_nxt;

  // Ready is low only in DONE, so a transfer is always in IDLE or ACTIVE.
  always_comb begin
    w_xfer      = i_data_valid && r_ready;
    w_sof_acc   = w_xfer && i_sof;
    w_px_acc    = w_xfer && (i_sof || (r_state == FB_ACTIVE));
    w_decim_eff = w_sof_acc ? i_decim : r_decim;
    w_idx_cur   = w_sof_acc ? '0 : r_idx;
  end

  fb_xy_counter #(
    .H_RES (H_RES),
    .V_RES (V_RES)
  ) u_xy (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (w_sof_acc),
    .i_advance (w_px_acc),
    .i_decim   (w_decim_eff),
    .o_x_last  (w_x_last),
    .o_y_last  (w_y_last),
    .o_keep    (w_keep)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= FB_IDLE;
    else       r_state <= w_state_nxt;
  end

  // A SOF pixel always restarts at (0,0), so it can never be the last one;
  // this is what makes SOF win over the last position.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FB_IDLE: begin
        if (w_sof_acc) w_state_nxt = FB_ACTIVE;
      end
      FB_ACTIVE: begin
        if (w_xfer && !i_sof && w_x_last && w_y_last) w_state_nxt = FB_DONE;
      end
      FB_DONE: w_state_nxt = FB_IDLE;
      default: w_state_nxt = FB_IDLE;
    endcase
  end

  always_comb begin
    w_ready_nxt = (w_state_nxt != FB_DONE);
    w_busy_nxt  = (w_state_nxt == FB_ACTIVE);
    w_done_nxt  = (w_state_nxt == FB_DONE);
    w_wr_nxt    = w_px_acc && w_keep;
  end

  // Address/data hold their last value between writes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ready <= 1'b0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_decim <= 1'b0;
      r_idx   <= '0;
    end else begin
      r_ready <= w_ready_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_wr    <= w_wr_nxt;
      if (w_sof_acc) r_decim <= i_decim;
      if (w_wr_nxt) begin
        r_addr <= AW'(BASE_ADDR) + AW'(w_idx_cur);
        r_data <= i_data;
        r_idx  <= w_idx_cur + 1'b1;
      end
    end
  end

  assign o_data_ready = r_ready;
  assign o_bram_wr    = r_wr;
  assign o_bram_addr  = r_addr;
  assign o_bram_data  = r_data;
  assign o_frame_done = r_done;
  assign o_busy       = r_busy;

`ifdef FB_WR_ERR_EN
  logic r_err;
  logic r_idle_err_seen;
  logic w_err_nxt;

  always_comb begin
    w_err_nxt = (w_sof_acc && (r_state == FB_ACTIVE)) ||
                (w_xfer && !i_sof && (r_state == FB_IDLE) && !r_idle_err_seen);
  end

  // The stray-pixel flag re-arms whenever the writer leaves IDLE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_err           <= 1'b0;
      r_idle_err_seen <= 1'b0;
    end else begin
      r_err <= w_err_nxt;
      if (r_state != FB_IDLE)
        r_idle_err_seen <= 1'b0;
      else if (w_xfer && !i_sof)
        r_idle_err_seen <= 1'b1;
    end
  end

  assign o_frame_err = r_err;
`else
  assign o_frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_fb_frame_writer.sv
// Bench for fb_frame_writer with H_RES=4, V_RES=2, BASE_ADDR=16, AW=8, DW=8.
// Each vector holds the inputs for one clock and the outputs expected just
// after that clock's rising edge.
module tb_fb_frame_writer;

  localparam int DW = 8;
  localparam int AW = 8;

`ifdef FB_WR_ERR_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          valid;
  logic          ready;
  logic [DW-1:0] data;
  logic          sof;
  logic          decim;
  logic          bram_wr;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_data;
  logic          frame_done;
  logic          busy;
  logic          frame_err;

  fb_frame_writer #(
    .DW        (DW),
    .H_RES     (4),
    .V_RES     (2),
    .BASE_ADDR (16),
    .AW        (AW)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_data_valid (valid),
    .o_data_ready (ready),
    .i_data       (data),
    .i_sof        (sof),
    .i_decim      (decim),
    .o_bram_wr    (bram_wr),
    .o_bram_addr  (bram_addr),
    .o_bram_data  (bram_data),
    .o_frame_done (frame_done),
    .o_busy       (busy),
    .o_frame_err  (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       valid;
    logic       sof;
    logic       decim;
    logic [7:0] data;
    logic       rdy;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdat;
    logic       done;
    logic       busy;
    logic       err;
  } vec_t;

  vec_t vq[$];
  int   errors = 0;
  int   checks = 0;
  int   row    = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at step %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  // v: valid, s: sof, d: decim, dat: pixel; then expected outputs.
  task automatic add(input logic r, input logic v, input logic s, input logic d,
                     input logic [7:0] dat, input logic rdy, input logic wr,
                     input logic [7:0] addr, input logic [7:0] wdat,
                     input logic done, input logic bsy, input logic err);
    vec_t e;
    e.rst = r; e.valid = v; e.sof = s; e.decim = d; e.data = dat;
    e.rdy = rdy; e.wr = wr; e.addr = addr; e.wdat = wdat;
    e.done = done; e.busy = bsy; e.err = err;
    vq.push_back(e);
  endtask

  // Kept pixel mid-frame: write at addr with its own data.
  task automatic kp(input logic s, input logic d, input logic [7:0] dat,
                    input logic [7:0] addr, input logic err);
    add(0, 1, s, d, dat, 1, 1, addr, dat, 0, 1, err);
  endtask

  task automatic idle_row();
    add(0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_outputs(input logic rdy_e, input logic wr_e,
                               input logic [7:0] addr_e, input logic [7:0] wdat_e,
                               input logic chk_ad, input logic done_e,
                               input logic busy_e, input logic err_e);
    chk("ready", {7'd0, ready}, {7'd0, rdy_e});
    chk("bram_wr", {7'd0, bram_wr}, {7'd0, wr_e});
    if (chk_ad) begin
      chk("bram_addr", bram_addr, addr_e);
      chk("bram_data", bram_data, wdat_e);
    end
    chk("frame_done", {7'd0, frame_done}, {7'd0, done_e});
    chk("busy", {7'd0, busy}, {7'd0, busy_e});
    chk("frame_err", {7'd0, frame_err}, {7'd0, err_e});
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; sof = 1'b0; decim = 1'b0; data = '0;

    // Reset, then idle.
    add(1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
    idle_row();
    // Pre-SOF garbage: dropped, one error pulse.
    add(0, 1, 0, 0, 8'h55, 1, 0, 0, 0, 0, 0, ERR);
    for (int i = 0; i < 4; i++) add(0, 1, 0, 0, 8'h55, 1, 0, 0, 0, 0, 0, 0);
    // Full frame, decim=0.
    kp(1, 0, 8'h10, 16, 0);
    for (int i = 1; i < 7; i++) kp(0, 0, 8'(8'h10 + i), 8'(16 + i), 0);
    add(0, 1, 0, 0, 8'h17, 0, 1, 23, 8'h17, 1, 0, 0);
    // Offered during DONE: not accepted.
    add(0, 1, 0, 0, 8'hEE, 1, 0, 0, 0, 0, 0, 0);
    // Stray pixel in IDLE after DONE: dropped.
    add(0, 1, 0, 0, 8'hEF, 1, 0, 0, 0, 0, 0, ERR);
    // Decim=1 frame; decim input flipped on later pixels must not matter.
    kp(1, 1, 8'h10, 16, 0);
    add(0, 1, 0, 0, 8'h11, 1, 0, 0, 0, 0, 1, 0);
    kp(0, 0, 8'h12, 17, 0);
    for (int i = 3; i < 7; i++) add(0, 1, 0, 0, 8'(8'h10 + i), 1, 0, 0, 0, 0, 1, 0);
    add(0, 1, 0, 0, 8'h17, 0, 0, 0, 0, 1, 0, 0);
    idle_row();
    // Resync: SOF + 3 pixels, then SOF + 8 pixels.
    kp(1, 0, 8'hB0, 16, 0);
    kp(0, 0, 8'hB1, 17, 0);
    kp(0, 0, 8'hB2, 18, 0);
    kp(1, 0, 8'hA0, 16, ERR);
    for (int i = 1; i < 7; i++) kp(0, 0, 8'(8'hA0 + i), 8'(16 + i), 0);
    add(0, 1, 0, 0, 8'hA7, 0, 1, 23, 8'hA7, 1, 0, 0);
    idle_row();
    // SOF on the last position: resync wins, no DONE.
    kp(1, 0, 8'hC0, 16, 0);
    for (int i = 1; i < 7; i++) kp(0, 0, 8'(8'hC0 + i), 8'(16 + i), 0);
    kp(1, 0, 8'hC7, 16, ERR);
    // Reset mid-frame after the 4th pixel.
    kp(0, 0, 8'hD1, 17, 0);
    kp(0, 0, 8'hD2, 18, 0);
    kp(0, 0, 8'hD3, 19, 0);
    add(1, 1, 0, 0, 8'hD4, 0, 0, 0, 0, 0, 0, 0);
    idle_row();
    add(0, 1, 0, 0, 8'hD5, 1, 0, 0, 0, 0, 0, ERR);
    kp(1, 0, 8'hE0, 16, 0);
    for (int i = 1; i < 7; i++) kp(0, 0, 8'(8'hE0 + i), 8'(16 + i), 0);
    add(0, 1, 0, 0, 8'hE7, 0, 1, 23, 8'hE7, 1, 0, 0);
    idle_row();

    @(posedge clk); #1;
    foreach (vq[k]) begin
      row   = k;
      rst   = vq[k].rst;
      valid = vq[k].valid;
      sof   = vq[k].sof;
      decim = vq[k].decim;
      data  = vq[k].data;
      @(posedge clk); #1;
      check_outputs(vq[k].rdy, vq[k].wr, vq[k].addr, vq[k].wdat,
                    vq[k].wr || vq[k].rst, vq[k].done, vq[k].busy, vq[k].err);
    end

    // Valid gaps: each pixel followed by an idle cycle.
    for (int i = 0; i < 8; i++) begin
      row   = 1000 + 2 * i;
      valid = 1'b1;
      sof   = (i == 0);
      decim = 1'b0;
      data  = 8'(8'h60 + i);
      @(posedge clk); #1;
      check_outputs(i != 7, 1'b1, 8'(16 + i), 8'(8'h60 + i), 1'b1,
                    i == 7, i != 7, 1'b0);
      row   = 1001 + 2 * i;
      valid = 1'b0;
      sof   = 1'b0;
      @(posedge clk); #1;
      check_outputs(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, i != 7, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fb_frame_writer.md
# fb_frame_writer

Frame-aware pixel writer sitting between the video-processing pipeline and the pixel frame-buffer BRAM. Accepts a valid/ready pixel stream with a start-of-frame marker, generates the frame-buffer write address from x/y position, and drives a BRAM write port at one pixel per cycle. Successor to the fixed 640x480 two-cycle handshake writer:
- parametrised in resolution, width and base address;
- resynchronises on start of frame;
- optional 2:1 decimation mode.

## Interface
Parameters:
- DW, 8, pixel data width
- H_RES, 640, active pixels per line (even, >= 2)
- V_RES, 480, active lines per frame (even, >= 2)
- BASE_ADDR, 0, first BRAM address of the frame
- AW, 19, BRAM address width; must hold BASE_ADDR + H_RES*V_RES - 1

Ports:
- i_clk  in  1  pixel/system clock
- i_rst  in  1  synchronous, active-high reset
- i_data_valid  in  1  upstream pixel valid
- o_data_ready  out  1  writer can accept a pixel
- i_data  in  DW  pixel data
- i_sof  in  1  start of frame; meaningful only when i_data_valid, marks first pixel
- i_decim  in  1  0 = full resolution, 1 = 2:1 subsample in x and y; sampled on SOF acceptance
- o_bram_wr  out  1  BRAM write enable
- o_bram_addr  out  AW  BRAM write address
- o_bram_data  out  DW  BRAM write data
- o_frame_done  out  1  one-cycle pulse after last pixel of a frame is accepted
- o_busy  out  1  high while in ACTIVE
- o_frame_err  out  1  one-cycle error pulse (see Configuration)

One clock; reset is synchronous and active-high (i_clk, i_rst).

## Operation
- Transfer occurs on a cycle with i_data_valid && o_data_ready.
- FSM states:
  - IDLE: ready=1. Transfers without i_sof are discarded. A transfer with i_sof goes to ACTIVE, latches i_decim and is processed as pixel (0,0).
  - ACTIVE: ready=1. Each transfer advances x (0..H_RES-1), then y (0..V_RES-1). A transfer at (H_RES-1, V_RES-1) goes to DONE.
  - DONE: ready=0 for exactly one cycle, o_frame_done=1, then IDLE.
- SOF while ACTIVE: resync. The pixel is treated as (0,0) of a new frame, i_decim is re-latched, and the write index is reset. The state stays ACTIVE and o_frame_done is not pulsed.
- Keep rule:
  - decim=0: every accepted pixel in a frame is written.
  - decim=1: only pixels with x[0]==0 && y[0]==0 are written.
  - Discarded pixels still advance x/y.
- Write index: reset to 0 on SOF, incremented after each kept pixel. o_bram_addr = BASE_ADDR + index, truncated to AW bits.
  - Maximum index is H_RES*V_RES-1 (decim=0) or (H_RES/2)*(V_RES/2)-1 (decim=1).
  - No wrap-around inside a frame.
- Pixels arriving in IDLE after DONE, before the next SOF, are dropped. Ready stays high so upstream never stalls.

## Timing
- Reset values:
  - state IDLE
  - o_data_ready 0 during reset, 1 on the first cycle after reset release
  - o_bram_wr 0, o_bram_addr 0, o_bram_data 0
  - o_frame_done 0, o_busy 0, o_frame_err 0
- Latency: a kept pixel accepted in cycle N gives o_bram_wr=1 with matching address and data in cycle N+1 (registered outputs).
- Throughput: 1 pixel/cycle within a frame. Only the single DONE cycle per frame stalls upstream.
- o_frame_done is asserted in cycle N+1 after the final pixel, coincident with that pixel's write (if kept).
- o_busy is registered and follows the state: high from the cycle after SOF acceptance through the final-pixel cycle.
- Reset mid-frame: i_rst in cycle N forces all outputs to reset values in N+1. No write is issued for a pixel accepted in cycle N-1 if its write would land at or after N+1. The next frame requires a fresh SOF.
- Simultaneous SOF and last position: SOF wins. The pixel is treated as resync (0,0) and no DONE is entered.

## Configuration
- FB_WR_ERR_EN defined: o_frame_err pulses in cycle N+1 for either of:
  - a short frame (SOF accepted in ACTIVE);
  - a transfer without SOF accepted in IDLE. This counts once per IDLE period only.
- FB_WR_ERR_EN undefined: o_frame_err is tied to 0, and the error logic is not built. The port stays present.

## Structure
- Package fb_pkg holds:
  - the state enum (FB_IDLE, FB_ACTIVE, FB_DONE);
  - the address-width helper function, a clog2 of H_RES*V_RES.
- Sub-module fb_xy_counter provides:
  - x/y counters with clear (SOF) and advance (transfer) inputs;
  - outputs x_last, y_last and keep.
- The FSM, write index and output registers live in fb_frame_writer.

## Test plan
Bench parameters: H_RES=4, V_RES=2, BASE_ADDR=16, AW=8, DW=8.
- Full frame, decim=0: SOF plus 8 back-to-back pixels 0x10..0x17. Writes to addresses 16..23 with data 0x10..0x17. o_frame_done pulses once, on the last write cycle. Ready is low for 1 cycle.
- Decim=1: same 8 pixels. Writes occur only for (0,0) and (2,0): addr 16 = 0x10, addr 17 = 0x12. o_frame_done still pulses after the 8th pixel.
- Resync: SOF plus 3 pixels, then SOF plus 8 pixels 0xA0..0xA7. Second frame writes addresses 16..23. One o_frame_done. With FB_WR_ERR_EN, o_frame_err pulses once, on the second SOF.
- Pre-SOF garbage: 5 pixels without SOF after reset. No o_bram_wr, ready stays 1. With FB_WR_ERR_EN, one o_frame_err pulse.
- Reset mid-frame: i_rst asserted after the 4th pixel, then released. All outputs read 0 on the following cycle, with no further writes. The next SOF restarts at addr 16.
- Valid gaps: valid toggled every other cycle over a full frame. Addresses stay contiguous 16..23, and each write follows its transfer by exactly 1 cycle.
